// File: rtl/uart_rx_responder_if.sv
// Receive-side bus of uart_rx_responder: byte valid/ready handshake plus
// line status (framing error, sticky overrun, busy) and the overrun clear.
interface uart_rx_responder_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 clr_overrun;
  logic                 busy;

  modport master (
    output data,
    output valid,
    output frame_err,
    output overrun,
    output busy,
    input  ready,
    input  clr_overrun
  );

  modport slave (
    input  data,
    input  valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output ready,
    output clr_overrun
  );

endinterface

// File: rtl/uart_rx_responder.sv
// 8N1-style asynchronous serial receiver, LSB first, idle-high line, with a
// one-entry valid/ready output buffer, sticky overrun and framing-error pulse.
module uart_rx_responder #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  uart_rx_responder_if.master    bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  logic                 rx_meta;
  logic                 rxs;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [BIT_W-1:0]     bit_q;
  logic [BIT_W-1:0]     bit_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 good_stop;
  logic                 bad_stop;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  // Two-flop synchronizer; resets to the idle level so a reset never looks
  // like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Data bits enter at the MSB and shift right, so after DATA_BITS samples
  // the first (LSB) bit has reached bit 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            good_stop = 1'b1;
            state_d   = S_IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = S_BRK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BRK: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A completed byte may replace one being consumed in the same cycle, so
  // back-to-back frames leave no bubble; otherwise a full buffer drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= bad_stop;

      if (good_stop) begin
        if (!valid_q || bus.ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end

      if (good_stop && valid_q && !bus.ready) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_responder.sv
// Self-checking bench for uart_rx_responder: directed and random frames scored
// every cycle against a timeline model of what each frame must produce.
module tb_uart_rx_responder;

  localparam int C        = 16;
  localparam int H        = C / 2;
  localparam int DB       = 8;
  localparam int MAXC     = 20000;
  // Stop sample edge after the start edge: 2 sync + 1 idle detect + half bit + 9 bits.
  localparam int STOP_OFS = 3 + H + 9 * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;

  uart_rx_responder_if #(.DATA_BITS(DB)) bus ();

  uart_rx_responder #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit         ev_good  [MAXC];
  logic [7:0] ev_byte  [MAXC];
  bit         ev_bad   [MAXC];
  bit         busy_arr [MAXC];

  bit         model_live  = 1'b0;
  logic [7:0] exp_data    = 8'h00;
  bit         exp_valid   = 1'b0;
  bit         exp_overrun = 1'b0;
  bit         exp_ferr    = 1'b0;
  bit         exp_busy    = 1'b0;

  int ready_mode     = 0;
  int clr_mode       = 0;
  int clr_force_edge = -1;

  int         ferr_count = 0;
  int         rise_cyc   = -1;
  logic       prev_valid = 1'b0;
  logic [7:0] accepted[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic markBusy(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (i >= 0 && i < MAXC) busy_arr[i] = 1'b1;
    end
  endtask

  // Sends one frame starting now; low_bits counts bit times the line stays
  // low from the start of a bad stop bit.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input int low_bits);
    int s;
    int t;
    int r;
    s = cyc;
    t = s + STOP_OFS;
    r = s + 9 * C + low_bits * C;
    if (t < MAXC) begin
      if (stop_ok) begin
        ev_good[t] = 1'b1;
        ev_byte[t] = b;
        markBusy(s + 3, t - 1);
      end else begin
        ev_bad[t] = 1'b1;
        markBusy(s + 3, r + 2);
      end
    end
    rxd = 1'b0;
    waitCycles(C);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      waitCycles(C);
    end
    if (stop_ok) begin
      rxd = 1'b1;
      waitCycles(C);
    end else begin
      rxd = 1'b0;
      waitCycles(low_bits * C);
      rxd = 1'b1;
      waitCycles(C);
    end
  endtask

  task automatic sendGlitch(input int g);
    int s;
    s = cyc;
    markBusy(s + 3, s + 2 + H);
    rxd = 1'b0;
    waitCycles(g);
    rxd = 1'b1;
    waitCycles(2 * C);
  endtask

  // Expected outputs after each edge, from the frame timeline and handshake rules.
  always @(posedge clk) begin : model
    int         k;
    bit         v;
    bit         o;
    bit         good;
    bit         set;
    logic [7:0] d;
    k    = cyc + 1;
    v    = exp_valid;
    o    = exp_overrun;
    d    = exp_data;
    good = (k < MAXC) && ev_good[k];
    set  = good && v && !bus.ready;
    if (rst) begin
      model_live <= 1'b1;
      v = 1'b0;
      o = 1'b0;
      d = 8'h00;
      exp_ferr <= 1'b0;
      exp_busy <= 1'b0;
    end else begin
      if (good) begin
        if (!set) begin
          d = ev_byte[k];
          v = 1'b1;
        end
      end else if (v && bus.ready) begin
        v = 1'b0;
      end
      if (set) o = 1'b1;
      else if (bus.clr_overrun) o = 1'b0;
      exp_ferr <= (k < MAXC) && ev_bad[k];
      exp_busy <= (k < MAXC) && busy_arr[k];
    end
    exp_valid   <= v;
    exp_overrun <= o;
    exp_data    <= d;
    cyc         <= k;
  end

  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("valid", 32'(bus.valid), 32'(exp_valid));
      checkOutput("data", 32'(bus.data), 32'(exp_data));
      checkOutput("overrun", 32'(bus.overrun), 32'(exp_overrun));
      checkOutput("frame_err", 32'(bus.frame_err), 32'(exp_ferr));
      checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
    end
    if (bus.frame_err === 1'b1) ferr_count++;
    if (bus.valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    if (bus.valid === 1'b1 && bus.ready === 1'b1) accepted.push_back(bus.data);
    prev_valid = bus.valid;
  end

  initial begin
    bus.ready       = 1'b0;
    bus.clr_overrun = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.ready = 1'b0;
        1:       bus.ready = 1'b1;
        default: bus.ready = ($urandom_range(0, 15) == 0);
      endcase
      bus.clr_overrun = (cyc + 1 == clr_force_edge) ||
                        (clr_mode == 2 && $urandom_range(0, 31) == 0);
    end
  end

  initial begin
    int         s1;
    int         s6;
    int         kind;
    logic [7:0] rb;
    logic [7:0] want2[2];
    want2[0] = 8'hA3;
    want2[1] = 8'h0F;

    rxd = 1'b1;
    rst = 1'b1;
    waitCycles(3);
    rst = 1'b0;
    waitCycles(2);
    checkOutput("reset_valid", 32'(bus.valid), 32'd0);
    checkOutput("reset_data", 32'(bus.data), 32'd0);
    checkOutput("reset_overrun", 32'(bus.overrun), 32'd0);
    checkOutput("reset_frame_err", 32'(bus.frame_err), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);

    $display("[TB] single frame 0x55, ready low");
    ready_mode = 0;
    rise_cyc   = -1;
    s1 = cyc;
    applyStimulus(8'h55, 1'b1, 0);
    checkOutput("t1_latency_window",
                32'((rise_cyc - s1 >= 153) && (rise_cyc - s1 <= 157)), 32'd1);
    checkOutput("t1_data", 32'(bus.data), 32'h55);
    checkOutput("t1_valid", 32'(bus.valid), 32'd1);
    checkOutput("t1_busy", 32'(bus.busy), 32'd0);
    checkOutput("t1_overrun", 32'(bus.overrun), 32'd0);
    checkOutput("t1_ferr_count", 32'(ferr_count), 32'd0);

    $display("[TB] back-to-back frames, ready high");
    ready_mode = 1;
    waitCycles(3);
    accepted.delete();
    applyStimulus(8'hA3, 1'b1, 0);
    applyStimulus(8'h0F, 1'b1, 0);
    waitCycles(4);
    checkOutput("t2_accept_count", 32'(accepted.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      checkOutput("t2_accept_byte",
                  (i < accepted.size()) ? 32'(accepted[i]) : 32'hDEAD, 32'(want2[i]));
    end
    checkOutput("t2_overrun", 32'(bus.overrun), 32'd0);

    $display("[TB] overrun with ready low");
    ready_mode = 0;
    waitCycles(2);
    applyStimulus(8'h11, 1'b1, 0);
    applyStimulus(8'h22, 1'b1, 0);
    checkOutput("t3_data_kept", 32'(bus.data), 32'h11);
    checkOutput("t3_valid", 32'(bus.valid), 32'd1);
    checkOutput("t3_overrun_set", 32'(bus.overrun), 32'd1);
    clr_force_edge = cyc + STOP_OFS;
    applyStimulus(8'h5A, 1'b1, 0);
    checkOutput("t3_set_beats_clear", 32'(bus.overrun), 32'd1);
    checkOutput("t3_data_still", 32'(bus.data), 32'h11);
    clr_force_edge = cyc + 2;
    ready_mode = 1;
    waitCycles(3);
    ready_mode = 0;
    waitCycles(2);
    clr_force_edge = -1;
    checkOutput("t3_overrun_cleared", 32'(bus.overrun), 32'd0);
    checkOutput("t3_drained", 32'(bus.valid), 32'd0);

    $display("[TB] framing error and held-low line");
    ferr_count = 0;
    applyStimulus(8'h7E, 1'b0, 41);
    checkOutput("t4_one_ferr", 32'(ferr_count), 32'd1);
    checkOutput("t4_valid_unchanged", 32'(bus.valid), 32'd0);
    checkOutput("t4_busy_released", 32'(bus.busy), 32'd0);
    applyStimulus(8'h3C, 1'b1, 0);
    checkOutput("t4_next_data", 32'(bus.data), 32'h3C);
    checkOutput("t4_next_valid", 32'(bus.valid), 32'd1);
    checkOutput("t4_ferr_total", 32'(ferr_count), 32'd1);

    $display("[TB] short low glitch");
    ferr_count = 0;
    sendGlitch(3);
    checkOutput("t5_valid", 32'(bus.valid), 32'd1);
    checkOutput("t5_data", 32'(bus.data), 32'h3C);
    checkOutput("t5_no_ferr", 32'(ferr_count), 32'd0);
    checkOutput("t5_idle", 32'(bus.busy), 32'd0);

    $display("[TB] reset in the middle of a frame");
    s6 = cyc;
    markBusy(s6 + 3, s6 + 63);
    rxd = 1'b0;
    waitCycles(C);
    rxd = 1'b1;
    waitCycles(63 - C);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    checkOutput("t6_valid", 32'(bus.valid), 32'd0);
    checkOutput("t6_data", 32'(bus.data), 32'd0);
    checkOutput("t6_busy", 32'(bus.busy), 32'd0);
    checkOutput("t6_overrun", 32'(bus.overrun), 32'd0);
    checkOutput("t6_frame_err", 32'(bus.frame_err), 32'd0);
    waitCycles(C);
    applyStimulus(8'h81, 1'b1, 0);
    checkOutput("t6_next_data", 32'(bus.data), 32'h81);
    checkOutput("t6_next_valid", 32'(bus.valid), 32'd1);

    $display("[TB] random frames, ready and clear");
    ready_mode = 2;
    clr_mode   = 2;
    for (int n = 0; n < 16; n++) begin
      if (cyc < MAXC - 2000) begin
        kind = $urandom_range(0, 11);
        rb   = 8'($urandom_range(0, 255));
        if (kind <= 9) applyStimulus(rb, 1'b1, 0);
        else if (kind == 10) applyStimulus(rb, 1'b0, $urandom_range(1, 3));
        else sendGlitch($urandom_range(1, H - 2));
        waitCycles($urandom_range(0, 20));
      end
    end
    ready_mode = 1;
    clr_mode   = 0;
    waitCycles(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
